// File: rtl/bc_pkg.sv
// Shared Basic Computer definitions: fetch FSM states, IR byte selects, address width.
package bc_pkg;

    localparam int ADDR_W_DEFAULT = 8;

    localparam logic IR_LOW  = 1'b0;
    localparam logic IR_HIGH = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_LO = 3'd1,
        ST_FETCH_HI = 3'd2,
        ST_DECODE   = 3'd3,
        ST_EXEC     = 3'd4,
        ST_HALTED   = 3'd5
    } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// Address register with synchronous reset, load and increment (Reset > Load > Inc).
// Single-cycle update; wraps modulo 2^ADDR_W.
module pc_counter
    import bc_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_VAL = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Load,
    input  logic              Inc,
    input  logic [ADDR_W-1:0] LoadValue,
    output logic [ADDR_W-1:0] Count
);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Count <= RESET_VAL;
        end else if (Load) begin
            Count <= LoadValue;
        end else if (Inc) begin
            Count <= Count + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ir_fetch_sequencer.sv
// Two-byte instruction fetch controller: owns PC, strobes the IR, handshakes with control unit.
// Fetch-to-InstrValid is 3 cycles minimum; each byte request is held until MemAck arrives.
module ir_fetch_sequencer
    import bc_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Start,
    output logic              MemReq,
    output logic [ADDR_W-1:0] MemAddr,
    input  logic              MemAck,
    output logic              IRWrite,
    output logic              IRLH,
    output logic              InstrValid,
    input  logic              ExecDone,
    input  logic              Halt,
    input  logic              PCLoad,
    input  logic [ADDR_W-1:0] PCIn,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy
);

    fetch_state_t state;
    logic         in_fetch;
    logic         pc_load;
    logic         pc_inc;

    assign in_fetch = (state == ST_FETCH_LO) || (state == ST_FETCH_HI);

    // Jumps only land between instructions so a fetch is never split across targets.
    assign pc_load = PCLoad && ((state == ST_IDLE) || (state == ST_EXEC) || (state == ST_HALTED));
    assign pc_inc  = in_fetch && MemAck;

    assign MemReq     = in_fetch;
    assign MemAddr    = PC;
    assign IRLH       = (state == ST_FETCH_HI) ? IR_HIGH : IR_LOW;
    assign IRWrite    = in_fetch && MemAck && !Reset;
    assign InstrValid = (state == ST_DECODE);
    assign Busy       = (state != ST_IDLE) && (state != ST_HALTED);

    pc_counter #(
        .ADDR_W    (ADDR_W),
        .RESET_VAL (RESET_PC)
    ) u_pc (
        .Clock     (Clock),
        .Reset     (Reset),
        .Load      (pc_load),
        .Inc       (pc_inc),
        .LoadValue (PCIn),
        .Count     (PC)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:     if (Start) state <= ST_FETCH_LO;
                ST_FETCH_LO: if (MemAck) state <= ST_FETCH_HI;
                ST_FETCH_HI: if (MemAck) state <= ST_DECODE;
                ST_DECODE:   state <= ST_EXEC;
                ST_EXEC:     if (ExecDone) state <= Halt ? ST_HALTED : ST_FETCH_LO;
                ST_HALTED:   state <= ST_HALTED;
                default:     state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// Directed bench for ir_fetch_sequencer with a byte memory model, an IR model and a scoreboard.
module tb_ir_fetch_sequencer;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       MemReq;
    logic [7:0] MemAddr;
    logic       MemAck;
    logic       IRWrite;
    logic       IRLH;
    logic       InstrValid;
    logic       ExecDone;
    logic       Halt;
    logic       PCLoad;
    logic [7:0] PCIn;
    logic [7:0] PC;
    logic       Busy;

    ir_fetch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start      (Start),
        .MemReq     (MemReq),
        .MemAddr    (MemAddr),
        .MemAck     (MemAck),
        .IRWrite    (IRWrite),
        .IRLH       (IRLH),
        .InstrValid (InstrValid),
        .ExecDone   (ExecDone),
        .Halt       (Halt),
        .PCLoad     (PCLoad),
        .PCIn       (PCIn),
        .PC         (PC),
        .Busy       (Busy)
    );

    typedef struct {
        logic        is_iv;
        logic [7:0]  addr;
        logic        lh;
        logic [15:0] ir;
        logic [7:0]  pc;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  mem[256];
    logic [15:0] ir_q;
    logic [7:0]  mem_bus;
    int          ack_delay  = 0;
    logic        ack_manual = 1'b0;
    int          wait_cnt   = 0;

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    assign mem_bus = mem[MemAddr];

    // Instruction register model: captures the addressed byte on the ack edge.
    always @(posedge Clock) begin
        if (IRWrite) begin
            if (IRLH) ir_q[15:8] <= mem_bus;
            else      ir_q[7:0]  <= mem_bus;
        end
    end

    // Memory responder: acks each request after ack_delay idle cycles.
    initial begin
        MemAck = 1'b0;
        forever begin
            @(posedge Clock);
            #1;
            if (!ack_manual) begin
                if (MemReq) begin
                    if (wait_cnt >= ack_delay) begin
                        MemAck   = 1'b1;
                        wait_cnt = 0;
                    end else begin
                        MemAck   = 1'b0;
                        wait_cnt++;
                    end
                end else begin
                    MemAck   = 1'b0;
                    wait_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_wr(input logic [7:0] addr, input logic lh);
        exp_t e;
        e.is_iv = 1'b0; e.addr = addr; e.lh = lh; e.ir = 16'h0; e.pc = 8'h0;
        sb.push_back(e);
    endtask

    task automatic push_iv(input logic [15:0] ir, input logic [7:0] pc);
        exp_t e;
        e.is_iv = 1'b1; e.addr = 8'h0; e.lh = 1'b0; e.ir = ir; e.pc = pc;
        sb.push_back(e);
    endtask

    // Monitor: every IR write and every InstrValid pulse must match the next expected event.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (IRWrite) begin
                checks++;
                if (sb.size() == 0 || sb[0].is_iv) begin
                    failures++;
                    $display("FAIL unexpected_irwrite addr=%h lh=%b", MemAddr, IRLH);
                end else begin
                    e = sb.pop_front();
                    if (MemAddr !== e.addr || IRLH !== e.lh) begin
                        failures++;
                        $display("FAIL irwrite actual addr=%h lh=%b expected addr=%h lh=%b",
                                 MemAddr, IRLH, e.addr, e.lh);
                    end
                end
            end
            if (InstrValid) begin
                checks++;
                if (sb.size() == 0 || !sb[0].is_iv) begin
                    failures++;
                    $display("FAIL unexpected_instrvalid ir=%h pc=%h", ir_q, PC);
                end else begin
                    e = sb.pop_front();
                    if (ir_q !== e.ir || PC !== e.pc) begin
                        failures++;
                        $display("FAIL instrvalid actual ir=%h pc=%h expected ir=%h pc=%h",
                                 ir_q, PC, e.ir, e.pc);
                    end
                end
            end
        end
    end

    // Steps from a negedge until InstrValid is seen at a negedge; n counts edges taken.
    task automatic wait_iv(input int max, output int n);
        n = 0;
        do begin
            @(posedge Clock);
            @(negedge Clock);
            Start = 1'b0;
            n++;
        end while (!InstrValid && n < max);
        if (!InstrValid) begin
            failures++;
            $display("FAIL iv_timeout actual=no_pulse expected=pulse within %0d cycles", max);
        end
    endtask

    task automatic next_neg();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h34; mem[8'h01] = 8'h12;
        mem[8'h02] = 8'h56; mem[8'h03] = 8'h9A;
        mem[8'h80] = 8'hCD; mem[8'h81] = 8'hAB;
        mem[8'hFF] = 8'h78;
        Reset = 1'b1; Start = 1'b0; ExecDone = 1'b0; Halt = 1'b0;
        PCLoad = 1'b0; PCIn = 8'h00;

        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        next_neg();
        chk("reset_pc", PC, 8'h00);
        chk("reset_memreq", MemReq, 1'b0);
        chk("reset_busy", Busy, 1'b0);
        chk("reset_irwrite", IRWrite, 1'b0);

        // T1 basic fetch, MemAck tied high
        push_wr(8'h00, 1'b0); push_wr(8'h01, 1'b1); push_iv(16'h1234, 8'h02);
        Start = 1'b1;
        wait_iv(20, n);
        chk("t1_latency", n, 3);
        ExecDone = 1'b1;
        next_neg();
        ExecDone = 1'b0;
        chk("t1_exec_ignores_done_in_decode", MemReq, 1'b0);
        chk("t1_busy_in_exec", Busy, 1'b1);

        // T2 four wait states per byte
        ack_delay = 4;
        push_wr(8'h02, 1'b0); push_wr(8'h03, 1'b1); push_iv(16'h9A56, 8'h04);
        ExecDone = 1'b1;
        @(posedge Clock);
        for (int c = 0; c < 10; c++) begin
            @(negedge Clock);
            ExecDone = 1'b0;
            chk("t2_memreq", MemReq, 1'b1);
            chk("t2_addr", MemAddr, (c < 5) ? 8'h02 : 8'h03);
            chk("t2_irlh", IRLH, (c < 5) ? 1'b0 : 1'b1);
            chk("t2_irwrite", IRWrite, (c == 4 || c == 9) ? 1'b1 : 1'b0);
            @(posedge Clock);
        end
        @(negedge Clock);
        chk("t2_instrvalid", InstrValid, 1'b1);
        ack_delay = 0;
        next_neg();

        // T3 jump with ExecDone, then PCLoad held during the fetch
        push_wr(8'h80, 1'b0); push_wr(8'h81, 1'b1); push_iv(16'hABCD, 8'h82);
        PCLoad = 1'b1; PCIn = 8'h80; ExecDone = 1'b1;
        next_neg();
        ExecDone = 1'b0; PCIn = 8'h40;
        chk("t3_jump_addr", MemAddr, 8'h80);
        next_neg();
        chk("t3_hi_addr", MemAddr, 8'h81);
        next_neg();
        chk("t3_decode_iv", InstrValid, 1'b1);
        next_neg();
        PCLoad = 1'b0;
        chk("t3_pc_in_exec", PC, 8'h82);

        // T5 halt
        ExecDone = 1'b1; Halt = 1'b1;
        next_neg();
        ExecDone = 1'b0; Halt = 1'b0;
        chk("t5_halted_busy", Busy, 1'b0);
        chk("t5_halted_memreq", MemReq, 1'b0);
        Start = 1'b1;
        next_neg();
        next_neg();
        Start = 1'b0;
        chk("t5_start_ignored_busy", Busy, 1'b0);
        chk("t5_start_ignored_memreq", MemReq, 1'b0);
        Reset = 1'b1;
        next_neg();
        Reset = 1'b0;
        chk("t5_reset_pc", PC, 8'h00);

        // T4 wrap from FF to 00
        PCLoad = 1'b1; PCIn = 8'hFF;
        next_neg();
        PCLoad = 1'b0;
        chk("t4_load_in_idle", PC, 8'hFF);
        chk("t4_idle_busy", Busy, 1'b0);
        push_wr(8'hFF, 1'b0); push_wr(8'h00, 1'b1); push_iv(16'h3478, 8'h01);
        Start = 1'b1;
        wait_iv(20, n);
        chk("t4_latency", n, 3);
        next_neg();

        // T6 reset during FETCH_HI with MemAck present
        push_wr(8'h01, 1'b0);
        ExecDone = 1'b1;
        next_neg();
        ExecDone = 1'b0;
        @(posedge Clock);
        #2;
        ack_manual = 1'b1; MemAck = 1'b1; Reset = 1'b1;
        @(negedge Clock);
        chk("t6_irwrite_in_reset", IRWrite, 1'b0);
        @(posedge Clock);
        #2;
        Reset = 1'b0;
        @(negedge Clock);
        chk("t6_pc", PC, 8'h00);
        chk("t6_memreq", MemReq, 1'b0);
        chk("t6_busy", Busy, 1'b0);
        chk("t6_irwrite_ack_in_idle", IRWrite, 1'b0);
        chk("t6_instrvalid", InstrValid, 1'b0);
        chk("t6_irlh", IRLH, 1'b0);
        next_neg();
        chk("t6_pc_stays_on_stray_ack", PC, 8'h00);
        ack_manual = 1'b0; MemAck = 1'b0;
        next_neg();

        chk("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
